// File: rtl/note_seq.sv
// note_seq: steps through a fixed 32-entry note ROM and emits timed note codes for a tone generator.
// Optional feature: define NOTE_SEQ_LOOP_EN for continuous playback; otherwise the song ends in DONE.
module note_seq #(
    parameter int unsigned time_beat = 25_000_000,
    parameter int unsigned gap_cyc   = 1_250_000,
    parameter int unsigned song_len  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    output logic [2:0] note_code,
    output logic       note_stb,
    output logic       song_done,
    output logic       busy
);

    localparam logic [2:0]  NOTE_REST = 3'd0;
    localparam logic [2:0]  NOTE_DO   = 3'd1;
    localparam logic [2:0]  NOTE_RI   = 3'd2;
    localparam logic [2:0]  NOTE_MI   = 3'd3;
    localparam logic [2:0]  NOTE_FA   = 3'd4;
    localparam logic [2:0]  NOTE_SO   = 3'd5;
    localparam logic [2:0]  NOTE_LA   = 3'd6;

    localparam logic [4:0]  LAST_IDX  = 5'(song_len - 1);
    localparam logic [31:0] BEAT_CYC  = 32'(time_beat);
    localparam logic [31:0] GAP_CYC   = 32'(gap_cyc);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  idx, idx_nxt;
    logic [31:0] timer, timer_nxt;
    logic        stb_nxt;

    logic [4:0]  entry;
    logic [2:0]  cur_note;
    logic [31:0] cur_dur;
    logic        last_cyc;
    logic        last_entry;

    // Each entry is {note, beats-1}; entries 0..3 are fixed, the rest is a free melody.
    function automatic logic [4:0] rom_entry(input logic [4:0] a);
        case (a)
            5'd0:  return {NOTE_DO,   2'd0};
            5'd1:  return {NOTE_MI,   2'd1};
            5'd2:  return {NOTE_SO,   2'd0};
            5'd3:  return {NOTE_REST, 2'd0};
            5'd4:  return {NOTE_DO,   2'd0};
            5'd5:  return {NOTE_DO,   2'd0};
            5'd6:  return {NOTE_SO,   2'd0};
            5'd7:  return {NOTE_SO,   2'd0};
            5'd8:  return {NOTE_LA,   2'd0};
            5'd9:  return {NOTE_LA,   2'd0};
            5'd10: return {NOTE_SO,   2'd1};
            5'd11: return {NOTE_FA,   2'd0};
            5'd12: return {NOTE_FA,   2'd0};
            5'd13: return {NOTE_MI,   2'd0};
            5'd14: return {NOTE_MI,   2'd0};
            5'd15: return {NOTE_RI,   2'd0};
            5'd16: return {NOTE_RI,   2'd0};
            5'd17: return {NOTE_DO,   2'd1};
            5'd18: return {NOTE_SO,   2'd0};
            5'd19: return {NOTE_SO,   2'd0};
            5'd20: return {NOTE_FA,   2'd0};
            5'd21: return {NOTE_FA,   2'd0};
            5'd22: return {NOTE_MI,   2'd0};
            5'd23: return {NOTE_MI,   2'd0};
            5'd24: return {NOTE_RI,   2'd1};
            5'd25: return {NOTE_SO,   2'd0};
            5'd26: return {NOTE_SO,   2'd0};
            5'd27: return {NOTE_FA,   2'd0};
            5'd28: return {NOTE_FA,   2'd0};
            5'd29: return {NOTE_MI,   2'd0};
            5'd30: return {NOTE_RI,   2'd0};
            5'd31: return {NOTE_DO,   2'd3};
        endcase
    endfunction

    function automatic logic [31:0] note_dur(input logic [1:0] beats);
        return ({30'd0, beats} + 32'd1) * BEAT_CYC;
    endfunction

    assign entry      = rom_entry(idx);
    assign cur_note   = entry[4:2];
    assign cur_dur    = note_dur(entry[1:0]);
    assign last_cyc   = (timer == cur_dur - 32'd1);
    assign last_entry = (idx == LAST_IDX);

    // The tail of every note is silent so repeated notes are heard as separate attacks.
    always_comb begin
        note_code = NOTE_REST;
        if (state == ST_PLAY && timer < cur_dur - GAP_CYC) begin
            note_code = cur_note;
        end
    end

    assign song_done = (state == ST_PLAY) && last_cyc && last_entry;
    assign busy      = (state == ST_PLAY) || (state == ST_PAUSE);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        timer_nxt = timer;
        stb_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (play) begin
                    state_nxt = ST_PLAY;
                    idx_nxt   = 5'd0;
                    timer_nxt = 32'd0;
                    stb_nxt   = 1'b1;
                end
            end
            ST_PLAY: begin
                timer_nxt = timer + 32'd1;
                state_nxt = play ? ST_PLAY : ST_PAUSE;
                // A note boundary always completes, even if play drops on that same cycle.
                if (last_cyc) begin
                    timer_nxt = 32'd0;
                    if (!last_entry) begin
                        idx_nxt = idx + 5'd1;
                        stb_nxt = 1'b1;
                    end else begin
`ifdef NOTE_SEQ_LOOP_EN
                        idx_nxt   = 5'd0;
                        stb_nxt   = 1'b1;
`else
                        idx_nxt   = 5'd0;
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
            ST_PAUSE: begin
                if (play) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_DONE: begin
                // Replay needs play to be released first.
                if (!play) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            idx      <= 5'd0;
            timer    <= 32'd0;
            note_stb <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            timer    <= timer_nxt;
            note_stb <= stb_nxt;
        end
    end

endmodule
